// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver (start, DATA_BITS LSB-first, stop).
// Optional parity bit and parity_err port when UART_RX_PARITY_EN is defined.
//
// Ports:
//   clk        - system clock, posedge
//   reset      - asynchronous active-high reset
//   baud_tick  - one-clk pulse at BAUD_RATE*OVERSAMPLE from tick generator
//   rx         - asynchronous serial line, idle high
//   baud_en    - enable to the tick generator (high when not IDLE)
//   rx_data    - last good received word
//   rx_valid   - one-clk pulse when rx_data is updated
//   frame_err  - one-clk pulse when the stop bit is sampled low
//   parity_err - one-clk pulse with rx_valid on parity mismatch (UART_RX_PARITY_EN)
//   busy       - high while not IDLE
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic                 baud_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
    localparam state_t S_AFTER_DATA = S_PARITY;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;
    localparam state_t S_AFTER_DATA = S_STOP;
`endif

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                end
            end
            // Half a bit in: confirm the start bit is still low.
            S_START: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            // From here on every sample lands mid-bit.
            S_DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_END) begin
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_AFTER_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_END) begin
                        par_bad_d  = rx_s_q ^ (^shift_q) ^ PARITY_ODD;
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
`endif
            // Leaving at mid-stop lets a back-to-back start edge be caught.
            S_STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_END) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d  = par_bad_q;
`endif
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign baud_en   = busy;
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver.
- Sits directly downstream of the baud tick generator: consumes its 16x `baud_tick` and drives its `en` input, so the tick phase restarts on every start-bit edge.
- Frame format: 1 start bit, DATA_BITS data bits (LSB first), 1 stop bit. Delivers each byte as a one-cycle valid pulse to the consumer (FIFO or CPU interface).

Parameters:
- DATA_BITS, 8, data bits per frame.
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and match the tick generator.
- PARITY_ODD, 0, parity sense (0 = even, 1 = odd); used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- baud_tick  input  1  one-clk pulse at BAUD_RATE*OVERSAMPLE from the tick generator.
- rx  input  1  serial line, asynchronous to clk, idle high.
- baud_en  output  1  enable to the tick generator; high whenever the FSM is not in IDLE.
- rx_data  output  DATA_BITS  last good received word.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous and active-high. In reset: rx_data=0, rx_valid=0, frame_err=0, busy=0, baud_en=0, FSM=IDLE, both synchronizer flops=1, all counters=0.
- rx passes through a 2-flop synchronizer; only rx_s (the synchronized value) is used.
- tick_cnt is $clog2(OVERSAMPLE) bits wide; bit_cnt is $clog2(DATA_BITS+1) bits wide; shift register is DATA_BITS wide.
- tick_cnt advances only on clocks where baud_tick=1. Elsewhere it holds.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On rx_s=0: go to START, set tick_cnt=0, assert baud_en in the next cycle.
  - The tick generator restarts from count 0.
- START:
  - On the tick where tick_cnt==OVERSAMPLE/2-1 (mid-bit), sample rx_s.
  - rx_s=0: go to DATA, clear tick_cnt and bit_cnt.
  - rx_s=1: glitch; go to IDLE with no outputs pulsed.
- DATA:
  - On the tick where tick_cnt==OVERSAMPLE-1: shift rx_s into the MSB of the shift register (right shift), clear tick_cnt, increment bit_cnt.
  - After the DATA_BITS-th sample, go to STOP.
  - Result: the first received bit ends up in rx_data[0].
- STOP: on the tick where tick_cnt==OVERSAMPLE-1, sample rx_s.
  - rx_s=1: rx_data<=shift register, pulse rx_valid for 1 clk, go to IDLE.
  - rx_s=0: pulse frame_err for 1 clk, leave rx_data unchanged, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. No new start bit is detected in BREAK.
- Latency: rx_valid and frame_err are registered and assert on the clk edge that processes the mid-stop-bit tick.
- IDLE is re-entered half a bit early, so back-to-back frames with no idle gap are received.
- rx_valid and frame_err are never asserted together.
- baud_en drops the cycle after IDLE is entered.
- Reset mid-frame: immediate return to the reset values. The partial word is discarded.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP. It samples one bit at tick_cnt==OVERSAMPLE-1.
  - Adds port parity_err (output, 1 bit).
  - Expected parity = XOR of the data bits XOR PARITY_ODD; a mismatch on the sampled bit is an error.
  - On a good stop bit with a parity mismatch: parity_err pulses 1 clk with rx_valid, and rx_data is still updated.
  - parity_err resets to 0.
- Undefined: no PARITY state and no parity_err port; the frame is as described above.

Test Plan:
- Assert reset with rx=1, then release -> all outputs 0, busy=0. Hold rx=1 for 10 bit times -> no pulses.
- With CLOCK_FREQ=50 MHz, 9600 baud, tick every 325 clk, send 0xA5 (line bits 1,0,1,0,0,1,0,1, stop=1) -> exactly one rx_valid pulse, rx_data=8'hA5, frame_err=0, busy falls after the mid-stop sample.
- Drive rx low for 3 ticks (<OVERSAMPLE/2), then high -> no rx_valid or frame_err; FSM back in IDLE; baud_en=0.
- Receive 0x11, then send 0x3C with stop bit 0 and rx held low 2 more bit times -> frame_err pulses once, rx_valid=0, rx_data stays 8'h11; busy stays high until rx returns high.
- Send 0x00 immediately followed by 0xFF with no idle gap -> two rx_valid pulses, rx_data=8'h00 then 8'hFF.
- Assert reset after 4 data bits of a frame, release, then send 0x5A -> outputs cleared during reset; the single rx_valid that follows carries rx_data=8'h5A.
